// File: rtl/maze_region_fill.sv
// -----------------------------------------------------------------------------
// maze_region_fill
//
// Rectangular-region writer for the maze frame RAM. A start request in IDLE
// latches an inclusive rectangle (x0..x1, y0..y1), a mode and a fill colour,
// then sweeps the rectangle in raster order (x fastest), one cell per cycle.
// Each cell is written either with the latched constant colour (fill mode)
// or with data read from an external source store (copy mode). Copy-mode
// source data arrives SRC_LAT cycles after the coordinate is presented.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   resetn       asynchronous active-low reset
//   start        operation request, sampled only in IDLE
//   mode         0 = copy from source, 1 = constant fill
//   fill_colour  constant colour for fill mode
//   x0, x1       inclusive column bounds
//   y0, y1       inclusive row bounds
//   src_x/src_y  source read coordinate (mirrors the sweep cursor)
//   src_data     source read data, SRC_LAT cycles behind src_x/src_y
//   wr_en        RAM write strobe
//   wr_addr      RAM write address {y, x}
//   wr_data      RAM write data
//   busy         operation in progress
//   done         one-cycle completion pulse
//   err          one-cycle pulse when a request with x0>x1 or y0>y1 is refused
// -----------------------------------------------------------------------------
module maze_region_fill #(
    parameter int GRID_W_BITS = 5,
    parameter int GRID_H_BITS = 5,
    parameter int COLOUR_W    = 3,
    parameter int SRC_LAT     = 1
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               start,
    input  logic                               mode,
    input  logic [COLOUR_W-1:0]                fill_colour,
    input  logic [GRID_W_BITS-1:0]             x0,
    input  logic [GRID_W_BITS-1:0]             x1,
    input  logic [GRID_H_BITS-1:0]             y0,
    input  logic [GRID_H_BITS-1:0]             y1,
    output logic [GRID_W_BITS-1:0]             src_x,
    output logic [GRID_H_BITS-1:0]             src_y,
    input  logic [COLOUR_W-1:0]                src_data,
    output logic                               wr_en,
    output logic [GRID_W_BITS+GRID_H_BITS-1:0] wr_addr,
    output logic [COLOUR_W-1:0]                wr_data,
    output logic                               busy,
    output logic                               done,
    output logic                               err
);

    localparam int AW = GRID_W_BITS + GRID_H_BITS;

    // Extra delay stages needed in front of the output register for the
    // slowest legal source (SRC_LAT = 3). Tap 0 is the live cursor.
    localparam int PIPE_D = 2;
    localparam logic [1:0] COPY_TAP = 2'(SRC_LAT - 1);

    localparam logic [GRID_W_BITS-1:0] X_ONE = GRID_W_BITS'(1);
    localparam logic [GRID_H_BITS-1:0] Y_ONE = GRID_H_BITS'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // Latched operation parameters
    logic [GRID_W_BITS-1:0] x0_reg, x1_reg;
    logic [GRID_H_BITS-1:0] y1_reg;
    logic                   mode_reg;
    logic [COLOUR_W-1:0]    fill_reg;

    // Sweep cursor
    logic [GRID_W_BITS-1:0] cur_x_reg;
    logic [GRID_H_BITS-1:0] cur_y_reg;

    // Latency pipe
    logic [PIPE_D-1:0]         pipe_vld_reg;
    logic [PIPE_D-1:0][AW-1:0] pipe_addr_reg;
    logic [PIPE_D:0]           tap_vld;
    logic [PIPE_D:0][AW-1:0]   tap_addr;
    logic [1:0]                tap_sel;
    logic                      sel_vld;
    logic [AW-1:0]             sel_addr;

    // Output registers
    logic                wr_en_reg;
    logic [AW-1:0]       wr_addr_reg;
    logic [COLOUR_W-1:0] wr_data_reg;
    logic                err_reg;

    logic accept;
    logic reject;
    logic bad_rect;
    logic at_row_end;
    logic at_last;

    assign bad_rect   = (x0 > x1) || (y0 > y1);
    assign at_row_end = (cur_x_reg == x1_reg);
    assign at_last    = at_row_end && (cur_y_reg == y1_reg);

    // Tap 0 is the coordinate being issued this cycle; tap k is that
    // coordinate delayed by k cycles. Fill mode writes straight from tap 0,
    // copy mode waits for the source data to line up.
    assign tap_vld  = {pipe_vld_reg, (state_reg == SCAN)};
    assign tap_addr = {pipe_addr_reg, {cur_y_reg, cur_x_reg}};
    assign tap_sel  = mode_reg ? 2'd0 : COPY_TAP;
    assign sel_vld  = tap_vld[tap_sel] && ((state_reg == SCAN) || (state_reg == DRAIN));
    assign sel_addr = tap_addr[tap_sel];

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (bad_rect) begin
                        reject = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = SCAN;
                    end
                end
            end
            SCAN: begin
                if (at_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Writes form one contiguous burst, so a write in flight with
                // nothing behind it at the selected tap is the final write.
                if (wr_en_reg && !sel_vld) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Operation latch and cursor
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x0_reg    <= '0;
            x1_reg    <= '0;
            y1_reg    <= '0;
            mode_reg  <= 1'b0;
            fill_reg  <= '0;
            cur_x_reg <= '0;
            cur_y_reg <= '0;
        end else if (accept) begin
            x0_reg    <= x0;
            x1_reg    <= x1;
            y1_reg    <= y1;
            mode_reg  <= mode;
            fill_reg  <= fill_colour;
            cur_x_reg <= x0;
            cur_y_reg <= y0;
        end else if (state_reg == SCAN) begin
            // Bounds are compared before incrementing, so a sweep ending at
            // the grid's maximum coordinate never rolls the cursor over.
            if (at_row_end) begin
                if (!at_last) begin
                    cur_x_reg <= x0_reg;
                    cur_y_reg <= cur_y_reg + Y_ONE;
                end
            end else begin
                cur_x_reg <= cur_x_reg + X_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Latency pipe and write port
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pipe_vld_reg  <= '0;
            pipe_addr_reg <= '0;
        end else begin
            pipe_vld_reg  <= tap_vld[PIPE_D-1:0];
            pipe_addr_reg <= tap_addr[PIPE_D-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            wr_en_reg <= sel_vld;
            err_reg   <= reject;
            if (sel_vld) begin
                wr_addr_reg <= sel_addr;
                wr_data_reg <= mode_reg ? fill_reg : src_data;
            end
        end
    end

    assign src_x   = cur_x_reg;
    assign src_y   = cur_y_reg;
    assign wr_en   = wr_en_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;
    assign err     = err_reg;
    assign busy    = (state_reg == SCAN) || (state_reg == DRAIN);
    assign done    = (state_reg == DONE);

endmodule

// File: tb/tb_maze_region_fill.sv
// -----------------------------------------------------------------------------
// tb_maze_region_fill
//
// Bench for maze_region_fill built with SRC_LAT = 2. Expected writes are
// pushed to a scoreboard queue when an operation is started and popped by a
// write monitor. A registered source model (one stage, matching SRC_LAT = 2)
// returns {x[1:0], y[0]} for each coordinate.
// -----------------------------------------------------------------------------
module tb_maze_region_fill;

    localparam int LAT_COPY = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        mode;
    logic [2:0]  fill_colour;
    logic [4:0]  x0, x1, y0, y1;
    logic [4:0]  src_x, src_y;
    logic [2:0]  src_data;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [2:0]  wr_data;
    logic        busy, done, err;

    always #5 clk = ~clk;

    maze_region_fill #(
        .GRID_W_BITS(5),
        .GRID_H_BITS(5),
        .COLOUR_W   (3),
        .SRC_LAT    (LAT_COPY)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .mode       (mode),
        .fill_colour(fill_colour),
        .x0         (x0),
        .x1         (x1),
        .y0         (y0),
        .y1         (y1),
        .src_x      (src_x),
        .src_y      (src_y),
        .src_data   (src_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    function automatic logic [2:0] src_fn(input logic [4:0] x, input logic [4:0] y);
        return {x[1:0], y[0]};
    endfunction

    // Source store with one register stage
    logic [2:0] src_q;
    always @(posedge clk) src_q <= src_fn(src_x, src_y);
    assign src_data = src_q;

    int total = 0;
    int bad   = 0;
    logic [12:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Write monitor: every write must match the head of the scoreboard
    always @(negedge clk) begin
        logic [12:0] e;
        if (wr_en === 1'b1) begin
            chk("write_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e[12:3]));
                chk("wr_data", 32'(wr_data), 32'(e[2:0]));
            end
        end
        if (done === 1'b1) begin
            chk("done_busy_excl", 32'(busy), 32'd0);
        end
    end

    task automatic push_rect(input logic m, input logic [2:0] col,
                             input logic [4:0] ax0, input logic [4:0] ay0,
                             input logic [4:0] ax1, input logic [4:0] ay1);
        for (int yy = int'(ay0); yy <= int'(ay1); yy++) begin
            for (int xx = int'(ax0); xx <= int'(ax1); xx++) begin
                logic [4:0] xv;
                logic [4:0] yv;
                logic [2:0] dv;
                xv = 5'(xx);
                yv = 5'(yy);
                dv = m ? col : src_fn(xv, yv);
                sb.push_back({yv, xv, dv});
            end
        end
    endtask

    // Called at a negedge with the DUT idle. Starts one operation, scrambles
    // the inputs after the accept edge, optionally re-pulses start at cycle
    // 'poke', and checks done timing, busy length and scoreboard drain.
    task automatic run_op(input string tag, input logic m, input logic [2:0] col,
                          input logic [4:0] ax0, input logic [4:0] ay0,
                          input logic [4:0] ax1, input logic [4:0] ay1,
                          input int lat, input int poke);
        int n;
        int idx;
        int busy_n;
        int done_idx;
        n = (int'(ax1) - int'(ax0) + 1) * (int'(ay1) - int'(ay0) + 1);
        mode = m; fill_colour = col;
        x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1;
        start = 1'b1;
        push_rect(m, col, ax0, ay0, ax1, ay1);
        idx = 0; busy_n = 0; done_idx = 0;
        while (done_idx == 0 && idx < n + lat + 20) begin
            @(negedge clk);
            idx++;
            if (idx == 1) begin
                start = 1'b0;
                mode = ~m; fill_colour = ~col;
                x0 = ax0 ^ 5'd7; x1 = ax1 ^ 5'd3; y0 = ay0 ^ 5'd1; y1 = ay1 ^ 5'd2;
            end
            if (poke != 0 && idx == poke) begin
                start = 1'b1;
                x0 = 5'd5; y0 = 5'd5; x1 = 5'd6; y1 = 5'd6;
            end
            if (poke != 0 && idx == poke + 1) start = 1'b0;
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) done_idx = idx;
        end
        start = 1'b0;
        chk({tag, "_done_at"}, 32'(done_idx), 32'(n + lat + 1));
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(n + lat));
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        $display("op %s n=%0d done_at=%0d busy_cycles=%0d", tag, n, done_idx, busy_n);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        int cyc;
        int wn;
        int dn;
        int bn;

        resetn = 1'b0; start = 1'b0; mode = 1'b0; fill_colour = 3'd0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en",   32'(wr_en),   32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_err",     32'(err),     32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_src_xy",  32'({src_y, src_x}), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        run_op("full_fill", 1'b1, 3'b101, 5'd0, 5'd0, 5'd31, 5'd31, 1, 0);
        run_op("copy",      1'b0, 3'b000, 5'd3, 5'd4, 5'd4, 5'd6, LAT_COPY, 0);
        run_op("corner",    1'b1, 3'b010, 5'd31, 5'd31, 5'd31, 5'd31, 1, 0);

        // Invalid rectangle, rows reversed
        mode = 1'b1; fill_colour = 3'd1;
        x0 = 5'd0; x1 = 5'd3; y0 = 5'd8; y1 = 5'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("bad_y_err",  32'(err),  32'd1);
        chk("bad_y_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("bad_y_err_pulse", 32'(err),   32'd0);
        chk("bad_y_no_write",  32'(wr_en), 32'd0);

        // Invalid rectangle, columns reversed, then a valid start at once
        x0 = 5'd10; x1 = 5'd9; y0 = 5'd0; y1 = 5'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("bad_x_err",   32'(err),   32'd1);
        chk("bad_x_busy",  32'(busy),  32'd0);
        chk("bad_x_done",  32'(done),  32'd0);
        chk("bad_x_wr_en", 32'(wr_en), 32'd0);
        run_op("after_err", 1'b1, 3'b110, 5'd0, 5'd0, 5'd1, 5'd0, 1, 0);

        run_op("mid_start", 1'b1, 3'b111, 5'd0, 5'd0, 5'd31, 5'd3, 1, 10);

        // Reset in the middle of a run, after the 40th write
        mode = 1'b1; fill_colour = 3'd4;
        x0 = 5'd0; y0 = 5'd0; x1 = 5'd31; y1 = 5'd31; start = 1'b1;
        push_rect(1'b1, 3'd4, 5'd0, 5'd0, 5'd31, 5'd31);
        n = 0; cyc = 0;
        while (n < 40 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (wr_en === 1'b1) n++;
        end
        chk("rst_mid_reached", 32'(n), 32'd40);
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid_wr_en", 32'(wr_en), 32'd0);
        chk("rst_mid_busy",  32'(busy),  32'd0);
        chk("rst_mid_done",  32'(done),  32'd0);
        chk("rst_mid_addr",  32'(wr_addr), 32'd0);
        chk("rst_mid_data",  32'(wr_data), 32'd0);
        chk("rst_mid_src",   32'({src_y, src_x}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        sb.delete();
        wn = 0; dn = 0; bn = 0;
        repeat (20) begin
            @(negedge clk);
            if (wr_en === 1'b1) wn++;
            if (done === 1'b1) dn++;
            if (busy === 1'b1) bn++;
        end
        chk("rst_mid_no_writes", 32'(wn), 32'd0);
        chk("rst_mid_no_done",   32'(dn), 32'd0);
        chk("rst_mid_no_busy",   32'(bn), 32'd0);
        $display("op reset_mid writes_before=%0d writes_after=%0d", n, wn);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/maze_region_fill.md
Name: maze_region_fill

Overview:
Parametrised rectangular-region writer for the maze frame RAM. On a start handshake it sweeps an inclusive rectangle of the grid in raster order. Each cell gets either a constant colour (fill mode) or a value read from a source store such as the maze text ROM (copy mode), with configurable source read latency. It sits between the game FSM and the maze RAM write port and replaces fixed whole-grid loaders; typical uses are whole-maze load, end-box repaint and sprite-cell clear.

Parameters:
GRID_W_BITS, 5, bits of x coordinate; grid width = 2^GRID_W_BITS
GRID_H_BITS, 5, bits of y coordinate; grid height = 2^GRID_H_BITS
COLOUR_W, 3, colour/data width
SRC_LAT, 1, source read latency in cycles, legal 1..3

Ports:
clk  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
mode  in  1  0 = copy from source, 1 = constant fill
fill_colour  in  COLOUR_W  fill value, latched at start
x0, x1  in  GRID_W_BITS each  inclusive column bounds, latched at start
y0, y1  in  GRID_H_BITS each  inclusive row bounds, latched at start
src_x  out  GRID_W_BITS  source read column
src_y  out  GRID_H_BITS  source read row
src_data  in  COLOUR_W  source value, valid SRC_LAT cycles after src_x/src_y
wr_en  out  1  RAM write strobe
wr_addr  out  GRID_W_BITS+GRID_H_BITS  {y, x}, i.e. y*2^GRID_W_BITS + x
wr_data  out  COLOUR_W  RAM write data
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse on rejected request

Behaviour:
- Reset, asynchronous: state = IDLE; wr_en, busy, done and err = 0; wr_addr, wr_data, src_x and src_y = 0; latency pipe cleared.
- Reset mid-operation: no further wr_en. The operation is abandoned and done does not pulse.
- States:
  - IDLE -> SCAN on start with a valid rectangle.
  - IDLE -> IDLE on start with x0>x1 or y0>y1: err pulses 1 cycle, no writes, busy stays 0.
  - SCAN -> DRAIN after the last coordinate is issued.
  - DRAIN -> DONE when the pipe is empty.
  - DONE -> IDLE after one cycle.
- Accept edge E0:
  - Bounds, mode and fill_colour are latched.
  - The cursor loads (x0,y0).
  - busy = 1 from the cycle after E0.
- SCAN:
  - One coordinate per cycle, x fastest: x increments; at x==x1, x returns to x0 and y increments.
  - The last coordinate is (x1,y1).
  - src_x/src_y mirror the cursor in both modes.
- Write pipe: a coordinate issued in the cycle after edge Ek is written (wr_en=1) in the cycle after edge Ek+L.
  - L = SRC_LAT in copy mode, L = 1 in fill mode.
  - Copy mode: wr_data = src_data as sampled at edge Ek+L.
  - Fill mode: wr_data = latched fill_colour.
  - wr_addr = delayed {y,x}.
- Exactly N = (x1-x0+1)*(y1-y0+1) writes, on consecutive cycles, no gaps or duplicates.
  - Coordinate arithmetic never wraps past the rectangle.
  - A full grid ending at max x/y must not overflow the cursor (compare before increment).
- Completion: done = 1 in the cycle after the last wr_en, i.e. the cycle after edge E0+N+L.
  - busy = 0 in that same cycle; done and busy are never both 1.
  - The next start is accepted from the edge ending the done cycle.
- start while busy or done: ignored, no effect on the current operation.
- Input changes after E0 (bounds, mode, fill_colour) do not affect the running operation.
- Single-cell rectangle (x0==x1, y0==y1): N=1, one write, legal.
- wr_en is 0 in IDLE and DONE and in any cycle without a valid pipe entry.

Test Plan:
- Full-grid fill, defaults: mode=1, fill_colour=3'b101, rect (0,0)-(31,31) -> 1024 consecutive writes, addr 0..1023 ascending, all data 5; done in the cycle after edge E0+1025; busy high 1024+1 cycles.
- Copy, SRC_LAT=2: model source data = {x[1:0],y[0]}, rect (3,4)-(4,6) -> 6 writes, addrs 131,132,163,164,195,196, each with that cell's model value; no misalignment.
- Corner cell: rect (31,31)-(31,31), fill 3'b010 -> exactly one write at addr 1023, data 2, then done; no wrap to addr 0.
- Invalid rect: x0=10, x1=9 -> err pulse one cycle, wr_en never asserted, busy 0, done 0; a valid start immediately after is accepted.
- Mid-run events, rect (0,0)-(31,3): start pulsed again mid-run with different bounds -> ignored, 128 writes, original bounds. Then resetn low after the 40th write of a new run -> all outputs 0 immediately, no further writes, no done pulse.
